// File: rtl/dual_phase_meter_pkg.sv
// Shared types and constants for the dual-phase meter.
package dual_phase_meter_pkg;
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_e;
endpackage

// File: rtl/dual_phase_meter_edge.sv
// Input sampling and edge detection for the dual-phase meter.
// Optional DUAL_PHASE_METER_SYNC_EN adds a 2-flop synchronizer ahead of s.
module dual_phase_meter_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_state,
  output logic rise,
  output logic fall
);
  logic s_in;
  logic s_q, s_d;
  // s_prev is the one-cycle-delayed copy of s
  logic s_prev_q, s_prev_d;

`ifdef DUAL_PHASE_METER_SYNC_EN
  logic [1:0] sync_q, sync_d;

  // two-stage synchronizer shift
  always_comb begin
    sync_d = {sync_q[0], i_state};
  end

  // synchronizer flops, cleared by reset
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) sync_q <= '0;
    else       sync_q <= sync_d;
  end

  assign s_in = sync_q[1];
`else
  assign s_in = i_state;
`endif

  // next values for the sample and its delayed copy
  always_comb begin
    s_d      = s_in;
    s_prev_d = s_q;
  end

  // sample register pair; both zero out of reset so a high input reads as a rise
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s_q      <= 1'b0;
      s_prev_q <= 1'b0;
    end else begin
      s_q      <= s_d;
      s_prev_q <= s_prev_d;
    end
  end

  assign rise = s_q & ~s_prev_q;
  assign fall = ~s_q & s_prev_q;
endmodule

// File: rtl/dual_phase_meter.sv
// Dual-phase meter: measures low and high phase lengths (minus 1) of a
// two-phase waveform and publishes them as a pair once per low+high cycle.
// Build option: DUAL_PHASE_METER_SYNC_EN (input synchronizer, +2 latency).
module dual_phase_meter
  import dual_phase_meter_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_state,
  output logic [CNT_W-1:0] o_bound1,
  output logic [CNT_W-1:0] o_bound2,
  output logic             o_valid,
  output logic             o_ovf,
  output logic             o_busy
);
  logic rise, fall, edge_any;
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, shadow_q, shadow_d;
  logic sat_q, sat_d, shadow_sat_q, shadow_sat_d;
  logic [CNT_W-1:0] pend_b1_q, pend_b1_d, pend_b2_q, pend_b2_d;
  logic pend_vld_q, pend_vld_d, pend_ovf_q, pend_ovf_d;
  logic [CNT_W-1:0] bound1_q, bound1_d, bound2_q, bound2_d;
  logic valid_q, valid_d, ovf_q, ovf_d;
  logic pair_done, latch_low;

  dual_phase_meter_edge u_edge (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_state(i_state),
    .rise   (rise),
    .fall   (fall)
  );

  assign edge_any = rise | fall;

  // FSM state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state; IDLE waits for a fall so a partial first phase is dropped
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fall) state_d = LOW;
      LOW:     if (rise) state_d = HIGH;
      HIGH:    if (fall) state_d = LOW;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: busy flag, low-phase latch strobe, pair-complete strobe
  always_comb begin
    o_busy    = (state_q != IDLE);
    latch_low = (state_q == LOW) && rise;
    pair_done = (state_q == HIGH) && fall;
  end

  // phase counter: cleared on edges, saturating increment otherwise
  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (edge_any) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (cnt_q == CNT_MAX) begin
      sat_d = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // low-phase shadow plus the staged pair waiting one cycle for publication
  always_comb begin
    shadow_d     = latch_low ? cnt_q : shadow_q;
    shadow_sat_d = latch_low ? sat_q : shadow_sat_q;
    pend_vld_d   = pair_done;
    pend_b1_d    = pair_done ? shadow_q : pend_b1_q;
    pend_b2_d    = pair_done ? cnt_q : pend_b2_q;
    pend_ovf_d   = pair_done ? (shadow_sat_q | sat_q) : pend_ovf_q;
  end

  // published outputs hold between valid pulses
  always_comb begin
    valid_d  = pend_vld_q;
    ovf_d    = pend_vld_q & pend_ovf_q;
    bound1_d = pend_vld_q ? pend_b1_q : bound1_q;
    bound2_d = pend_vld_q ? pend_b2_q : bound2_q;
  end

  // datapath registers; reset drops any partial pair
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q        <= '0;
      sat_q        <= 1'b0;
      shadow_q     <= '0;
      shadow_sat_q <= 1'b0;
      pend_vld_q   <= 1'b0;
      pend_b1_q    <= '0;
      pend_b2_q    <= '0;
      pend_ovf_q   <= 1'b0;
      valid_q      <= 1'b0;
      ovf_q        <= 1'b0;
      bound1_q     <= '0;
      bound2_q     <= '0;
    end else begin
      cnt_q        <= cnt_d;
      sat_q        <= sat_d;
      shadow_q     <= shadow_d;
      shadow_sat_q <= shadow_sat_d;
      pend_vld_q   <= pend_vld_d;
      pend_b1_q    <= pend_b1_d;
      pend_b2_q    <= pend_b2_d;
      pend_ovf_q   <= pend_ovf_d;
      valid_q      <= valid_d;
      ovf_q        <= ovf_d;
      bound1_q     <= bound1_d;
      bound2_q     <= bound2_d;
    end
  end

  assign o_bound1 = bound1_q;
  assign o_bound2 = bound2_q;
  assign o_valid  = valid_q;
  assign o_ovf    = ovf_q;
endmodule

// File: doc/dual_phase_meter.md
DUAL_PHASE_METER -- requirements
Module: dual_phase_meter

Interface
REQ-001 SHALL have these ports: i_clk  input  1  sole clock, all logic on its rising edge.
REQ-002 SHALL have these ports: i_rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have these ports: i_state  input  1  two-phase waveform; low phase then high phase, repeating.
REQ-004 SHALL have these ports: o_bound1  output  8  measured low-phase length minus 1.
REQ-005 SHALL have these ports: o_bound2  output  8  measured high-phase length minus 1.
REQ-006 SHALL have these ports: o_valid  output  1  one-cycle pulse, new o_bound1/o_bound2 pair published.
REQ-007 SHALL have these ports: o_ovf  output  1  qualifies o_valid; either phase of the pair saturated.
REQ-008 SHALL have these ports: o_busy  output  1  high while a measurement pair is in progress, which is every state except IDLE.

Function
REQ-009 SHALL register i_state into s, delay s by one cycle into s_d, and detect a rising edge (s=1, s_d=0) or falling edge (s=0, s_d=1).
REQ-010 SHALL implement FSM states IDLE, LOW, HIGH.
REQ-011 SHALL transition IDLE->LOW on a falling edge; IDLE ignores rising edges, so a partial first phase is never reported.
REQ-012 SHALL transition LOW->HIGH on a rising edge, latching the phase count into the bound1 shadow register and its saturation flag.
REQ-013 SHALL transition HIGH->LOW on a falling edge; next cycle o_bound2 = count, o_bound1 = shadow, o_valid = 1, o_ovf = OR of both saturation flags.
REQ-014 SHALL clear the phase counter to 0 on each edge cycle and increment it every other cycle.
REQ-015 SHALL make a phase of N sampled cycles report N-1; minimum phase 1 cycle reports 0.
REQ-016 SHALL make the 8-bit counter saturate at 255, never wrap, and set that phase's saturation flag.
REQ-017 SHALL hold o_bound1/o_bound2 between o_valid pulses; o_valid SHALL be high exactly one cycle per completed LOW+HIGH pair.
REQ-018 SHALL make back-to-back pairs valid; the falling edge ending HIGH also starts the next LOW measurement.
REQ-019 SHALL make o_valid latency 3 cycles without sync: i_state falling at cycle t gives o_valid at t+3.
REQ-020 SHALL match the counter generator: bounds B1,B2 give low B1+1 and high B2+1 cycles, reported as o_bound1=B1 and o_bound2=B2.

Reset
REQ-021 SHALL, while i_rst=1, force state=IDLE, s=s_d=0, counter=0, shadow=0, flags=0, o_bound1=0, o_bound2=0, o_valid=0, o_ovf=0, o_busy=0.
REQ-022 SHALL, on reset asserted mid-measurement, discard the partial pair without emitting o_valid.
REQ-023 SHALL, after release, make s_d=0 hold so a high i_state yields a rising edge, which IDLE ignores.

Configuration
REQ-024 SHALL, with DUAL_PHASE_METER_SYNC_EN defined, insert a 2-flop synchronizer before s, making o_valid latency 5 cycles and reset value 0.
REQ-025 SHALL, without DUAL_PHASE_METER_SYNC_EN, sample i_state directly into s; i_state is then treated as synchronous to i_clk.

Structure
REQ-026 SHALL place in package dual_phase_meter_pkg: FSM state enum (IDLE/LOW/HIGH), CNT_W=8, CNT_MAX=255.
REQ-027 SHALL place the optional synchronizer, s/s_d registers and edge detect in sub-module dual_phase_meter_edge with outputs rise, fall.

Verification
REQ-028 SHALL cover basic: low 4, high 6 cycles repeated -> o_bound1=3, o_bound2=5, o_valid every 10 cycles, o_ovf=0.
REQ-029 SHALL cover minimum: alternating 1-cycle phases -> o_bound1=0, o_bound2=0, o_valid every 2 cycles.
REQ-030 SHALL cover saturation: low 300, high 2 cycles -> o_bound1=255, o_bound2=1, o_ovf=1 with o_valid; next normal pair -> o_ovf=0.
REQ-031 SHALL cover start-up: i_state high at reset release, high 7, low 3, high 5 -> first o_valid gives o_bound1=2, o_bound2=4.
REQ-032 SHALL cover mid-reset: i_rst pulsed during HIGH -> no o_valid, outputs 0; first pair after re-acquisition reported correctly.
REQ-033 SHALL cover latency: fall at cycle t -> o_valid at t+3; repeat with DUAL_PHASE_METER_SYNC_EN defined -> t+5.
